// File: rtl/stream_demux1to2_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one input stream, two
// registered output streams and the per-port packet counters.
interface stream_demux1to2_if #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
);
   logic [WIDTH-1:0]     in_data;
   logic                 in_sel;
   logic                 in_last;
   logic                 in_valid;
   logic                 in_ready;

   logic [WIDTH-1:0]     out0_data;
   logic                 out0_last;
   logic                 out0_valid;
   logic                 out0_ready;

   logic [WIDTH-1:0]     out1_data;
   logic                 out1_last;
   logic                 out1_valid;
   logic                 out1_ready;

   logic [CNT_WIDTH-1:0] cnt0;
   logic [CNT_WIDTH-1:0] cnt1;
   logic                 busy;

   // Demux side.
   modport slave (
      input  in_data, in_sel, in_last, in_valid, out0_ready, out1_ready,
      output in_ready, out0_data, out0_last, out0_valid,
             out1_data, out1_last, out1_valid, cnt0, cnt1, busy
   );

   // Producer/consumer side.
   modport master (
      output in_data, in_sel, in_last, in_valid, out0_ready, out1_ready,
      input  in_ready, out0_data, out0_last, out0_valid,
             out1_data, out1_last, out1_valid, cnt0, cnt1, busy
   );
endinterface

// File: rtl/stream_demux1to2.sv
// Registered 1-to-2 valid/ready demultiplexer. The destination is chosen
// on the head beat of a packet and held until its last beat; each output
// port has a one-entry register slice. WIDTH/CNT_WIDTH must match the
// parameters of the connected interface instance.
module stream_demux1to2 #(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   stream_demux1to2_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               r_state;
   state_t               w_next;

   logic [WIDTH-1:0]     r_data0, r_data1;
   logic                 r_last0, r_last1;
   logic                 r_valid0, r_valid1;
   logic [CNT_WIDTH-1:0] r_cnt0, r_cnt1;

   logic                 w_tgt;
   logic                 w_ready;
   logic                 w_acc;
   logic                 w_load0, w_load1;
   logic                 w_drain0, w_drain1;

   // Target port: in_sel while idle, otherwise the locked port.
   assign w_tgt    = (r_state == LOCK0) ? 1'b0 :
                     (r_state == LOCK1) ? 1'b1 : bus.in_sel;

   // Ready depends only on the target slot, never on in_valid; a full slot
   // that is draining this cycle still accepts.
   assign w_ready  = w_tgt ? (!r_valid1 || bus.out1_ready)
                           : (!r_valid0 || bus.out0_ready);
   assign w_acc    = bus.in_valid && w_ready;
   assign w_load0  = w_acc && !w_tgt;
   assign w_load1  = w_acc &&  w_tgt;
   assign w_drain0 = r_valid0 && bus.out0_ready;
   assign w_drain1 = r_valid1 && bus.out1_ready;

   // Route FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Route FSM next-state: lock on a multi-beat head, release on last beat.
   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch forms.
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_acc && !bus.in_last) w_next = bus.in_sel ? LOCK1 : LOCK0;
         end
         LOCK0, LOCK1: begin
            if (w_acc && bus.in_last) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Port register slices: load on accept, clear valid on drain-only.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: payload registers are reset too, so outputs read as zero
         // after reset rather than holding stale data.
         r_data0  <= '0;
         r_last0  <= 1'b0;
         r_valid0 <= 1'b0;
         r_data1  <= '0;
         r_last1  <= 1'b0;
         r_valid1 <= 1'b0;
      end else begin
         if (w_load0) begin
            r_data0  <= bus.in_data;
            r_last0  <= bus.in_last;
            r_valid0 <= 1'b1;
         end else if (w_drain0) begin
            r_valid0 <= 1'b0;
         end
         if (w_load1) begin
            r_data1  <= bus.in_data;
            r_last1  <= bus.in_last;
            r_valid1 <= 1'b1;
         end else if (w_drain1) begin
            r_valid1 <= 1'b0;
         end
      end
   end

   // Per-port packet counters, counting accepted last beats; wrap freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_load0 && bus.in_last) r_cnt0 <= r_cnt0 + CNT_ONE;
         if (w_load1 && bus.in_last) r_cnt1 <= r_cnt1 + CNT_ONE;
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.out0_data  = r_data0;
   assign bus.out0_last  = r_last0;
   assign bus.out0_valid = r_valid0;
   assign bus.out1_data  = r_data1;
   assign bus.out1_last  = r_last1;
   assign bus.out1_valid = r_valid1;
   assign bus.cnt0       = r_cnt0;
   assign bus.cnt1       = r_cnt1;
   assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_stream_demux1to2.sv
// Self-checking bench for stream_demux1to2: directed scenarios followed by
// randomized traffic, all compared against a packet-level reference model
// built from per-port expected-beat queues.
module tb_stream_demux1to2;

   localparam int W  = 8;
   localparam int CW = 2;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } beat_t;

   logic clk = 1'b0;
   logic rst;

   stream_demux1to2_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

   stream_demux1to2 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   beat_t q0[$];
   beat_t q1[$];
   bit    m_lock;
   bit    m_port;
   int    n0, n1;
   bit    chk_en;
   bit    g_acc;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] wrap_cnt(input int n);
      return 32'(n % (1 << CW));
   endfunction

   // One clock cycle: drive, check at negedge, advance model at posedge.
   task automatic cyc(input logic r, input logic v, input logic s,
                      input logic l, input logic [W-1:0] d,
                      input logic r0, input logic r1);
      bit tgt, exp_rdy;
      beat_t b;
      rst            = r;
      bus.in_valid   = v;
      bus.in_sel     = s;
      bus.in_last    = l;
      bus.in_data    = d;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
      tgt     = m_lock ? m_port : s;
      exp_rdy = tgt ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
      @(negedge clk);
      g_acc = bus.in_valid && bus.in_ready;
      if (chk_en) begin
         check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         check("v0", 32'(bus.out0_valid), 32'(q0.size() != 0));
         check("v1", 32'(bus.out1_valid), 32'(q1.size() != 0));
         if (q0.size() != 0) begin
            check("d0", 32'(bus.out0_data), 32'(q0[0].d));
            check("l0", 32'(bus.out0_last), 32'(q0[0].l));
         end
         if (q1.size() != 0) begin
            check("d1", 32'(bus.out1_data), 32'(q1[0].d));
            check("l1", 32'(bus.out1_last), 32'(q1[0].l));
         end
         check("busy", 32'(bus.busy), 32'(m_lock));
         check("cnt0", 32'(bus.cnt0), wrap_cnt(n0));
         check("cnt1", 32'(bus.cnt1), wrap_cnt(n1));
      end
      @(posedge clk);
      if (r) begin
         q0.delete();
         q1.delete();
         m_lock = 1'b0;
         n0 = 0;
         n1 = 0;
         chk_en = 1'b1;
      end else if (chk_en) begin
         if (q0.size() != 0 && r0) void'(q0.pop_front());
         if (q1.size() != 0 && r1) void'(q1.pop_front());
         if (v && exp_rdy) begin
            b.d = d;
            b.l = l;
            if (tgt) q1.push_back(b);
            else     q0.push_back(b);
            if (l) begin
               if (tgt) n1++;
               else     n0++;
               m_lock = 1'b0;
            end else begin
               m_lock = 1'b1;
               m_port = tgt;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input logic r0, input logic r1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, r0, r1);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int acc_cnt;
      logic pv, ps, pl, rr0, rr1;
      logic [W-1:0] pd;

      chk_en = 1'b0;
      m_lock = 1'b0;
      n0 = 0;
      n1 = 0;

      // Reset state.
      do_reset();
      check("rst_d0", 32'(bus.out0_data), 32'h0);
      check("rst_d1", 32'(bus.out1_data), 32'h0);
      check("rst_l0", 32'(bus.out0_last), 32'h0);
      check("rst_l1", 32'(bus.out1_last), 32'h0);
      check("rst_rdy", 32'(bus.in_ready), 32'h1);

      // Single-beat packet to port 1.
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1);
      check("a5_v1", 32'(bus.out1_valid), 32'h1);
      check("a5_d1", 32'(bus.out1_data), 32'hA5);
      check("a5_cnt1", 32'(bus.cnt1), 32'h1);
      check("a5_busy", 32'(bus.busy), 32'h0);
      check("a5_v0", 32'(bus.out0_valid), 32'h0);
      idle(1'b1, 1'b1);

      // Four-beat packet locked to port 0 despite in_sel toggling.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, (i != 0), (i == 3), 8'(8'h10 + i), 1'b1, 1'b1);
         check("pk_busy", 32'(bus.busy), 32'(i != 3));
         check("pk_d0", 32'(bus.out0_data), 32'(8'h10 + i));
      end
      check("pk_cnt0", 32'(bus.cnt0), 32'h1);
      idle(1'b1, 1'b1);

      // Back-pressure on port 0.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1);
      check("bp_stall", 32'(g_acc), 32'h0);
      check("bp_hold", 32'(bus.out0_data), 32'h20);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 1'b1, 1'b1);
      check("bp_same", 32'(g_acc), 32'h1);
      check("bp_new", 32'(bus.out0_data), 32'h21);
      idle(1'b1, 1'b1);

      // Head-of-line: port 0 stalled, head to port 1 passes.
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h31, 1'b0, 1'b1);
      check("hol_p1", 32'(g_acc), 32'h1);
      idle(1'b1, 1'b1);
      // Lock to port 0 and stall it; port 1 empty does not help.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1);
      check("hol_lock", 32'(g_acc), 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1);
      idle(1'b1, 1'b1);

      // Full-rate alternating single-beat packets.
      do_reset();
      acc_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b1, i[0], 1'b1, 8'(8'h50 + i), 1'b1, 1'b1);
         if (g_acc) acc_cnt++;
      end
      check("stream_acc", 32'(acc_cnt), 32'd20);
      check("stream_c0", 32'(bus.cnt0), wrap_cnt(10));
      check("stream_c1", 32'(bus.cnt1), wrap_cnt(10));
      idle(1'b1, 1'b1);

      // Counter wrap: five packets to port 1 with a 2-bit counter.
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
      check("wrap_cnt1", 32'(bus.cnt1), 32'h1);

      // Reset mid-packet.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
      check("mid_busy", 32'(bus.busy), 32'h1);
      do_reset();
      check("mid_v0", 32'(bus.out0_valid), 32'h0);
      check("mid_v1", 32'(bus.out1_valid), 32'h0);
      check("mid_busy0", 32'(bus.busy), 32'h0);
      check("mid_cnt1", 32'(bus.cnt1), 32'h0);

      // Randomized traffic; an offered beat is held until accepted.
      pv = 1'b0; ps = 1'b0; pl = 1'b0; pd = '0;
      g_acc = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!pv || g_acc) begin
            pv = ($urandom_range(0, 3) != 0);
            ps = 1'($urandom);
            pl = ($urandom_range(0, 2) == 0);
            pd = 8'($urandom);
         end
         rr0 = ($urandom_range(0, 3) != 0);
         rr1 = ($urandom_range(0, 3) != 0);
         cyc(1'b0, pv, ps, pl, pd, rr0, rr1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stream_demux1to2.md
# stream_demux1to2

Registered 1-to-2 valid/ready stream demultiplexer: the splitting counterpart of the datapath's 2:1 select mux. Beats arriving on one input stream go to output port 0 or port 1. The port is chosen by `in_sel` on the first beat of a packet and held until that packet's last beat. Each output has a one-entry register slice, so the block sits between a producer and two independent consumers (e.g., splitting a token stream between two compute lanes) and breaks the data timing path.

## Interface
- `WIDTH`, 8, data width in bits
- `CNT_WIDTH`, 16, width of per-port packet counters

- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `in_data`  input  WIDTH  input beat payload
- `in_sel`  input  1  destination port, sampled only on the first beat of a packet
- `in_last`  input  1  marks final beat of a packet
- `in_valid`  input  1  input beat valid
- `in_ready`  output  1  block accepts the beat this cycle
- `out0_data` / `out1_data`  output  WIDTH  registered payload per port
- `out0_last` / `out1_last`  output  1  registered last flag per port
- `out0_valid` / `out1_valid`  output  1  port register holds a beat
- `out0_ready` / `out1_ready`  input  1  consumer accepts the port's beat
- `cnt0` / `cnt1`  output  CNT_WIDTH  packets (last beats) accepted into each port
- `busy`  output  1  a packet is in progress (route locked)

## Operation
- Accept = `in_valid && in_ready`. Port drain k = `outk_valid && outk_ready`.
- Route FSM has three states: IDLE, LOCK0, LOCK1.
  - IDLE: target = `in_sel`. An accepted beat with `in_last`=0 moves to LOCK[in_sel]. An accepted beat with `in_last`=1 (single-beat packet) stays in IDLE.
  - LOCKk: target = k and `in_sel` is ignored. An accepted beat with `in_last`=1 returns to IDLE. Otherwise the FSM stays in LOCKk.
- `in_ready` = `!outT_valid || outT_ready`, where T is the current target. The check is combinational on the target's ready, so a full-and-draining register accepts in the same cycle.
- Head-of-line rule: when the target is full and stalled, `in_ready`=0 even if the other port is empty.
- On accept, register T loads `in_data` and `in_last`, and `outT_valid` is set to 1.
- Per port, a drain without a load clears `outk_valid`. A load together with a drain keeps it at 1 with the new data. The non-target port is never loaded. It only drains.
- `outk_data`/`outk_last` hold their value while `outk_valid`=1 and `outk_ready`=0.
- `cntk` increments by 1 on each accepted beat with `in_last`=1 routed to k. It wraps modulo 2^CNT_WIDTH with no saturation.
- `busy` = (state != IDLE).
- Upstream obligation: once `in_valid` is asserted, `in_data`/`in_sel`/`in_last` stay stable until accept. The block does not check this.

## Timing
- Reset values: all `outk_valid`=0, `outk_data`=0, `outk_last`=0, `cntk`=0, state IDLE, `busy`=0. `in_ready` follows its equation, so it is 1 after reset.
- Reset mid-packet drops both register contents and returns to IDLE the next cycle. The dropped packet is not counted beyond beats already counted.
- Latency: accept at edge N gives `outk_valid`=1 in cycle N+1.
- Throughput: 1 beat/cycle into a port whose consumer holds ready=1. The two ports never both load in the same cycle.
- `in_ready` has a combinational path from `outk_ready` and state. There is no combinational path from `in_valid` to `in_ready`.
- `busy` and the FSM state update at the edge of the accepting cycle. The beat after a multi-beat head sees LOCK.

## Test plan
- Reset, then a single-beat packet (`in_sel`=1, data 0xA5, last=1) with `out1_ready`=1:
  - `out1_valid`=1 with 0xA5 on the next cycle.
  - `cnt1`=1, `busy` stays 0.
  - `out0_valid` stays 0.
- 4-beat packet (0x10–0x13) starting with `in_sel`=0, with `in_sel` toggled to 1 on beats 2–4:
  - All four beats appear on port 0 in order.
  - `busy`=1 from after beat 1 until after beat 4, then `cnt0`=1.
- Back-pressure: `out0_ready`=0 with port 0 loaded, next beat targets port 0:
  - `in_ready`=0.
  - `out0_data` holds steady.
  - Raising `out0_ready` accepts the new beat in the same cycle and it appears the next cycle.
- Head-of-line: port 0 full and stalled, new packet head with `in_sel`=1:
  - `in_ready`=1 and the beat goes to port 1, since the target is port 1.
  - While LOCK0 with port 0 stalled, `in_ready`=0 despite port 1 being empty.
- Full-rate streaming, alternating single-beat packets to ports 0/1 with both readies high for 20 cycles:
  - No bubbles.
  - `cnt0`=`cnt1`=10.
  - Data order is preserved per port.
- Counter wrap with `CNT_WIDTH`=2: after 5 packets to port 1, `cnt1`=1. Separately, assert `rst` mid-packet:
  - Next cycle both valids are 0, state is IDLE, counters are 0.
